// File: rtl/uart_pkg.sv
// Shared defaults and 50 MHz divisor table for the UART baud generator.
// Each divisor entry is one oversample period (OVS_DEF ticks per bit) in clock cycles.
package uart_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OVS_DEF    = 16;
    localparam int PH_W_DEF   = $clog2(OVS_DEF);

    typedef struct packed {
        logic [DIV_W_DEF-1:0]  div_int;
        logic [FRAC_W_DEF-1:0] div_frac;
    } baud_div_t;

    // 50e6 / (16 * baud), fraction in 1/16 steps
    localparam baud_div_t BAUD_9600   = '{div_int: 16'd325, div_frac: 4'd8};
    localparam baud_div_t BAUD_57600  = '{div_int: 16'd54,  div_frac: 4'd4};
    localparam baud_div_t BAUD_115200 = '{div_int: 16'd27,  div_frac: 4'd2};

    function automatic int ph_width(input int ovs);
        return (ovs < 2) ? 1 : $clog2(ovs);
    endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider: shadow divisor, interval counter and fraction accumulator.
// tc flags the terminal-count edge so the parent can advance its phase in lock-step.
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tc,
    output logic              tick_ovs,
    output logic              div_err
);

    localparam int CNT_W = DIV_W + 1;

    logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              tick_q, tick_d;
    logic              div_err_q, div_err_d;
    logic [CNT_W-1:0]  period;
    logic [FRAC_W:0]   acc_sum;

    always_comb begin
        period  = {1'b0, shadow_int_q} + CNT_W'(carry_q);
        acc_sum = {1'b0, acc_q} + {1'b0, shadow_frac_q};
        tc      = en && !restart && !div_err_q && (cnt_q == period - CNT_W'(1));
    end

    always_comb begin
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        carry_d       = carry_q;
        tick_d        = 1'b0;
        // A restart beats a coinciding terminal count, so that tick is dropped.
        if (restart) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            if (load) begin
                shadow_int_d  = div_int;
                shadow_frac_d = div_frac;
            end
        end else if (tc) begin
            cnt_d            = '0;
            {carry_d, acc_d} = acc_sum;
            tick_d           = 1'b1;
        end else if (en && !div_err_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        div_err_d = (shadow_int_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_int_q  <= DIV_W'(DEF_INT);
            shadow_frac_q <= FRAC_W'(DEF_FRAC);
            cnt_q         <= '0;
            acc_q         <= '0;
            carry_q       <= 1'b0;
            tick_q        <= 1'b0;
            div_err_q     <= (DEF_INT == 0);
        end else begin
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            carry_q       <= carry_d;
            tick_q        <= tick_d;
            div_err_q     <= div_err_d;
        end
    end

    assign tick_ovs = tick_q;
    assign div_err  = div_err_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: oversample, mid-bit and bit ticks plus phase index.
// Load and Sync both restart the phase; Load additionally latches a new divisor.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int OVS      = OVS_DEF,
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 2
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     En,
    input  logic [DIV_W-1:0]         Div_int,
    input  logic [FRAC_W-1:0]        Div_frac,
    input  logic                     Load,
    input  logic                     Sync,
    output logic                     Tick_ovs,
    output logic                     Tick_mid,
    output logic                     Tick_bit,
    output logic [ph_width(OVS)-1:0] Phase,
    output logic                     Div_err
);

    localparam int PH_W = ph_width(OVS);

    logic            restart;
    logic            tc;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            mid_q, mid_d;
    logic            bit_q, bit_d;

    assign restart = Load | Sync;

    uart_frac_divider #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_div (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .en       (En),
        .load     (Load),
        .restart  (restart),
        .div_int  (Div_int),
        .div_frac (Div_frac),
        .tc       (tc),
        .tick_ovs (Tick_ovs),
        .div_err  (Div_err)
    );

    // Phase steps on the same edge that raises Tick_ovs, so decode the new value.
    always_comb begin
        phase_d = phase_q;
        mid_d   = 1'b0;
        bit_d   = 1'b0;
        if (restart) begin
            phase_d = '0;
        end else if (tc) begin
            phase_d = phase_q + PH_W'(1);
            mid_d   = (phase_d == PH_W'(OVS / 2));
            bit_d   = (phase_d == '0);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            phase_q <= '0;
            mid_q   <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mid_q   <= mid_d;
            bit_q   <= bit_d;
        end
    end

    assign Phase    = phase_q;
    assign Tick_mid = mid_q;
    assign Tick_bit = bit_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench: each restart pushes the predicted tick times/phases, a monitor pops
// and compares them as Tick_ovs pulses arrive; any tick with nothing queued is an error.
module tb_uart_baud_gen_frac;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;
    localparam int PH_W   = 4;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b1;
    logic              En = 1'b1;
    logic              Load = 1'b0;
    logic              Sync = 1'b0;
    logic [DIV_W-1:0]  Div_int = '0;
    logic [FRAC_W-1:0] Div_frac = '0;
    logic              Tick_ovs, Tick_mid, Tick_bit, Div_err;
    logic [PH_W-1:0]   Phase;

    uart_baud_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_INT(27), .DEF_FRAC(2)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .Div_int(Div_int), .Div_frac(Div_frac),
        .Load(Load), .Sync(Sync), .Tick_ovs(Tick_ovs), .Tick_mid(Tick_mid),
        .Tick_bit(Tick_bit), .Phase(Phase), .Div_err(Div_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int cyc;
        int ph;
        bit is_mid;
        bit is_bit;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  n_pass = 0;
    int  n_chk  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    endtask

    // Interval timing model: first interval after restart uses carry 0.
    task automatic expect_ticks(input int base, input int di, input int df, input int n);
        int   t, acc, carry, ph;
        ev_t  e;
        t = base; acc = 0; carry = 0; ph = 0;
        for (int k = 0; k < n; k++) begin
            t     = t + di + carry;
            acc   = acc + df;
            carry = (acc >= (1 << FRAC_W)) ? 1 : 0;
            acc   = acc % (1 << FRAC_W);
            ph    = (ph + 1) % OVS;
            e.cyc = t; e.ph = ph; e.is_mid = (ph == OVS / 2); e.is_bit = (ph == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Called at a negedge; the following posedge (cycle c) captures the strobe.
    task automatic do_load(input int di, input int df, input bit ld, input bit sy, output int c);
        Div_int  = DIV_W'(di);
        Div_frac = FRAC_W'(df);
        Load     = ld;
        Sync     = sy;
        c        = cyc + 1;
        @(negedge Clk);
        Load = 1'b0;
        Sync = 1'b0;
    endtask

    always @(posedge Clk) begin
        cyc = cyc + 1;
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missed_tick", 0, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (Tick_ovs) begin
            if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
                chk("unexpected_tick", Tick_ovs, 0);
            end else begin
                chk("tick_cyc", cyc, exp_q[0].cyc);
                chk("tick_phase", Phase, exp_q[0].ph);
                chk("tick_mid", Tick_mid, exp_q[0].is_mid);
                chk("tick_bit", Tick_bit, exp_q[0].is_bit);
                void'(exp_q.pop_front());
            end
        end else if (Tick_mid || Tick_bit) begin
            chk("stray_mid_bit", {Tick_mid, Tick_bit}, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #2 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_tick_ovs", Tick_ovs, 0);
        chk("rst_tick_mid", Tick_mid, 0);
        chk("rst_tick_bit", Tick_bit, 0);
        chk("rst_phase", Phase, 0);
        chk("rst_div_err", Div_err, 0);
        Rst_n = 1'b1;
        expect_ticks(cyc, 27, 2, 3);
        drain("rst_default");

        // 1: integer divisor 4; a Div_int change without Load must be ignored
        do_load(4, 0, 1'b1, 1'b0, c);
        expect_ticks(c, 4, 0, 34);
        Div_int = 16'd7;
        drain("div4");

        // 2: 27.125 -> 9th and 17th intervals are 28 cycles
        do_load(27, 2, 1'b1, 1'b0, c);
        expect_ticks(c, 27, 2, 18);
        drain("div27_2");

        // 3: zero divisor stalls, then divisor 1 ticks every cycle
        do_load(0, 0, 1'b1, 1'b0, c);
        chk("div0_err", Div_err, 1);
        repeat (1000) @(negedge Clk);
        chk("div0_err_hold", Div_err, 1);
        chk("div0_phase", Phase, 0);
        do_load(1, 0, 1'b1, 1'b0, c);
        chk("div1_err", Div_err, 0);
        expect_ticks(c, 1, 0, 40);
        drain("div1");

        // 4: Sync at cnt=6/Phase=5 keeps divisor 10, ignores inputs
        do_load(10, 0, 1'b1, 1'b0, c);
        expect_ticks(c, 10, 0, 5);
        drain("div10");
        repeat (6) @(negedge Clk);
        chk("pre_sync_phase", Phase, 5);
        do_load(3, 5, 1'b0, 1'b1, c);
        chk("sync_phase", Phase, 0);
        expect_ticks(c, 10, 0, 3);
        drain("sync");
        do_load(8, 0, 1'b1, 1'b1, c);
        expect_ticks(c, 8, 0, 20);
        drain("load_sync");

        // 5: En gap of 7 cycles at cnt=3, then Load on a terminal count
        do_load(10, 0, 1'b1, 1'b0, c);
        expect_ticks(c + 7, 10, 0, 3);
        repeat (3) @(negedge Clk);
        En = 1'b0;
        repeat (7) @(negedge Clk);
        En = 1'b1;
        drain("en_gap");
        repeat (9) @(negedge Clk);
        do_load(10, 0, 1'b1, 1'b0, c);
        expect_ticks(c, 10, 0, 2);
        drain("load_at_tc");

        // 6: async reset while ticks are continuously high
        do_load(1, 0, 1'b1, 1'b0, c);
        expect_ticks(c, 1, 0, 5);
        drain("pre_rst");
        chk("pre_rst_tick", Tick_ovs, 1);
        chk("pre_rst_phase", Phase, 5);
        #1 Rst_n = 1'b0;
        #1;
        chk("mid_rst_tick", Tick_ovs, 0);
        chk("mid_rst_phase", Phase, 0);
        chk("mid_rst_div_err", Div_err, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        expect_ticks(cyc, 27, 2, 17);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Parametrised fractional baud-rate generator for the UART_232 transmitter and receiver. It produces three tick strobes from a runtime-loadable divisor:
- an oversample tick;
- a mid-bit tick for RX sampling;
- a bit tick.

It adds a fractional divisor, shadow-register divisor loading, an enable, and phase resynchronisation on the RX start edge. It sits between the system clock and the UART TX/RX state machines.

Parameters:
DIV_W, 16, width of integer divisor.
FRAC_W, 4, width of fractional divisor; fraction resolution is 1/2^FRAC_W.
OVS, 16, oversample ticks per bit; must be an even power of two, at least 2.
DEF_INT, 27, integer divisor loaded at reset.
DEF_FRAC, 2, fractional divisor loaded at reset.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
En  input  1  count enable; low freezes counters.
Div_int  input  DIV_W  integer part of oversample period, in Clk cycles.
Div_frac  input  FRAC_W  fractional part of oversample period.
Load  input  1  strobe: copy Div_int/Div_frac into shadow and restart phase.
Sync  input  1  strobe: restart phase, keep divisor (RX start-edge alignment).
Tick_ovs  output  1  oversample tick, one-cycle pulse.
Tick_mid  output  1  pulse coincident with the (OVS/2)-th Tick_ovs of each bit.
Tick_bit  output  1  pulse coincident with the OVS-th Tick_ovs of each bit.
Phase  output  log2(OVS)  oversample-tick index within current bit.
Div_err  output  1  high while shadow integer divisor is 0.

Behaviour:
- Reset (async assert, sync release):
  - shadow_int=DEF_INT, shadow_frac=DEF_FRAC;
  - cnt=0, acc=0, carry=0, Phase=0;
  - all ticks 0; Div_err=(DEF_INT==0).
- Divisor inputs are sampled only on Load. Changes without Load are ignored.
- Interval period P = shadow_int + carry.
  - carry is the overflow of acc+shadow_frac computed at the previous interval end.
  - The first interval after reset, Load or Sync uses carry=0.
- Each enabled cycle:
  - if cnt==P-1: cnt<=0; {carry,acc}<=acc+shadow_frac; Tick_ovs<=1 (registered);
  - else: cnt<=cnt+1; Tick_ovs<=0.
- Latency: Tick_ovs is high in the cycle after the P-th enabled edge following a restart. Subsequent ticks are spaced P cycles apart.
- Average period is shadow_int + shadow_frac/2^FRAC_W cycles.
- Phase advances by 1 modulo OVS on each Tick_ovs, in the same cycle the tick is asserted.
  - Tick_mid=1 when Phase becomes OVS/2.
  - Tick_bit=1 when Phase wraps to 0.
  - Both are one-cycle pulses, registered alongside Tick_ovs.
- shadow_int==1: P=1 (or 2 on carry), so Tick_ovs may stay high continuously. This is legal.
- shadow_int==0: Div_err=1; cnt, acc and Phase are held at 0; no ticks are produced.
- En=0: cnt, acc, carry and Phase are frozen; all tick outputs are 0 the next cycle. On En re-assertion, counting resumes from the frozen value.
- Load=1:
  - next edge: shadow<=inputs; cnt, acc, carry and Phase <=0; ticks <=0;
  - Div_err is updated from the new Div_int;
  - this acts regardless of En.
- Sync=1: same as Load except the shadow is unchanged.
- Load and Sync in the same cycle: Load wins; the result is identical.
- Load/Sync coinciding with a terminal count: the restart wins and no tick is emitted.
- Rst_n asserted mid-interval: immediate return to reset values; no partial pulse is held.
- Arithmetic:
  - cnt is DIV_W+1 bits wide so that P=2^DIV_W-1+1 does not overflow.
  - acc is FRAC_W bits and wraps with carry out.

Decomposition:
- Package uart_pkg holds:
  - DIV_W, FRAC_W and OVS defaults;
  - the log2(OVS) width constant;
  - divisor constants for 50 MHz at 9600, 57600 and 115200 baud, e.g. 115200 → int 27, frac 2 (27.125).
- Sub-module uart_frac_divider contains cnt, acc and carry, with outputs Tick_ovs and Div_err.
- The top level adds the Phase counter, Tick_mid/Tick_bit decode and Load/Sync priority.

Test Plan:
1. Load Div_int=4, Div_frac=0, En=1 → Tick_ovs every 4 cycles; first tick 4 cycles after Load; Tick_mid every 64 cycles, offset 32 from Tick_bit; Tick_bit every 64 cycles.
2. Load Div_int=27, Div_frac=2 → over 16 oversample intervals, 14 are 27 cycles and 2 are 28 cycles (the 9th and the 1st after wrap); Tick_bit spacing is 434 cycles.
3. Load Div_int=0 → Div_err=1, no ticks for 1000 cycles. Then Load Div_int=1 → Div_err=0, Tick_ovs high every cycle, Tick_bit every 16 cycles.
4. Div_int=10, Sync at cnt=6, Phase=5 → Phase=0 and next Tick_ovs 10 cycles after Sync. Sync and Load asserted together with Div_int=8 → period 8.
5. Div_int=10, drop En for 7 cycles at cnt=3 → no ticks during the gap; next tick 6 enabled cycles after resume. Load at the terminal count cycle → no tick that cycle.
6. Rst_n pulse mid-bit → outputs 0, Phase=0, shadow=27/2 immediately; first Tick_ovs 27 cycles after release.
